// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse_meter block: state encoding,
// edge-select mode codes and the edge qualification helper.
package pulse_meter_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        RUN        = 2'd2
    } state_t;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic logic edge_selected(input logic [1:0] mode,
                                           input logic       rise,
                                           input logic       fall);
        logic sel;
        sel = 1'b0;
        case (mode)
            MODE_NONE: sel = 1'b0;
            MODE_RISE: sel = rise;
            MODE_FALL: sel = fall;
            MODE_BOTH: sel = rise | fall;
            default:   sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pulse_meter_edge_det.sv
// Input history register with combinational rise/fall detection.
// The history keeps tracking the input regardless of enable.
module edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise,
    output logic fall
);

    logic in_q;

    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_q <= RST_VAL;
        else     in_q <= in;
    end

    assign rise = in & ~in_q;
    assign fall = ~in & in_q;

endmodule

// File: rtl/pulse_meter.sv
// Edge counter with threshold interrupt plus rising-edge period measurement
// with saturation/overflow detection.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int   CNT_W      = CNT_W_DEF,
    parameter logic RST_VAL_IN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] thresh,
    input  logic             ack,
    output logic             irq,
    output logic [CNT_W-1:0] evt_cnt,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rise, fall;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] pcnt, pcnt_nxt, period_nxt;
    logic             vld_nxt, ovf_set;
    logic [CNT_W-1:0] evt_base, evt_nxt;
    logic             irq_nxt, count_en;

    edge_det #(.RST_VAL(RST_VAL_IN)) u_edge_det (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .rise (rise),
        .fall (fall)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        pcnt_nxt   = pcnt;
        period_nxt = period;
        vld_nxt    = 1'b0;
        ovf_set    = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            pcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = WAIT_FIRST;
                    pcnt_nxt  = '0;
                end
                WAIT_FIRST: begin
                    if (rise) begin
                        state_nxt = RUN;
                        pcnt_nxt  = CNT_ONE;
                    end
                end
                RUN: begin
                    if (rise) begin
                        period_nxt = pcnt;
                        vld_nxt    = 1'b1;
                        pcnt_nxt   = CNT_ONE;
                    end else if (pcnt == CNT_MAX) begin
                        // Period too long to measure: flag it and re-arm on the next rise.
                        ovf_set   = 1'b1;
                        state_nxt = WAIT_FIRST;
                        pcnt_nxt  = '0;
                    end else begin
                        pcnt_nxt = pcnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    pcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Ack clears first, so an edge in the ack cycle counts from zero.
    always_comb begin
        count_en = en && (state != IDLE);
        evt_base = ack ? '0 : evt_cnt;
        evt_nxt  = evt_base;
        irq_nxt  = irq & ~ack;
        if (count_en && edge_selected(mode, rise, fall) && (evt_base != CNT_MAX)) begin
            evt_nxt = evt_base + CNT_ONE;
            if ((thresh != '0) && (evt_nxt == thresh)) irq_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pcnt       <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            evt_cnt    <= '0;
            irq        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nxt;
            pcnt       <= pcnt_nxt;
            period     <= period_nxt;
            period_vld <= vld_nxt;
            evt_cnt    <= evt_nxt;
            irq        <= irq_nxt;
            ovf        <= (ovf & ~ack) | ovf_set;
        end
    end

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 Parameter CNT_W, default 32, width of event counter, threshold and period counter.
REQ-002 Parameter RST_VAL_IN, default 1'b0, reset value of the input history register.
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port en  input  1  block enable; 0 forces state IDLE, counters hold.
REQ-006 Port in  input  1  filtered, clk-synchronous signal from the upstream filter stage (its out).
REQ-007 Port mode  input  2  edge select: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 Port thresh  input  CNT_W  event count at which irq is raised; 0 disables irq.
REQ-009 Port ack  input  1  single-cycle irq acknowledge.
REQ-010 Port irq  output  1  level interrupt, held until ack.
REQ-011 Port evt_cnt  output  CNT_W  selected-edge count since last ack or reset.
REQ-012 Port period  output  CNT_W  clk cycles between the last two rising edges of in.
REQ-013 Port period_vld  output  1  one-cycle strobe when period updates.
REQ-014 Port ovf  output  1  sticky flag: period counter saturated; cleared by ack.

Function
REQ-015 in is registered into in_q each cycle; rise = in & ~in_q, fall = ~in & in_q.
REQ-016 Selected edge = (mode[0] & rise) | (mode[1] & fall); evt_cnt increments on the clock edge that captures the edge into in_q (1-cycle latency from in change).
REQ-017 evt_cnt saturates at all-ones; no wrap.
REQ-018 irq sets on the clock edge where evt_cnt becomes equal to thresh (thresh != 0); further edges keep counting with irq held.
REQ-019 ack while irq=1 clears irq, ovf and evt_cnt; a selected edge in the same cycle as ack yields evt_cnt=1 and irq=0 (unless thresh=1, then irq=1).
REQ-020 ack while irq=0 clears evt_cnt and ovf only.
REQ-021 FSM states: IDLE, WAIT_FIRST, RUN.
REQ-022 IDLE -> WAIT_FIRST when en=1; any state -> IDLE when en=0 (period counter cleared, evt_cnt/irq held).
REQ-023 WAIT_FIRST -> RUN on first rise; period counter loads 1, no period_vld.
REQ-024 In RUN, period counter increments each cycle; on rise, period <= counter value, period_vld=1 next cycle, counter reloads 1.
REQ-025 Period counter saturates at all-ones: sets ovf, FSM -> WAIT_FIRST, period unchanged, no period_vld.
REQ-026 Edge detection on in continues in IDLE (in_q tracks in) but no counting; re-enable does not produce a spurious edge.
REQ-027 Changing mode or thresh mid-operation takes effect next cycle; lowering thresh below evt_cnt does not raise irq.

Reset
REQ-028 On rst: in_q=RST_VAL_IN, state=IDLE, evt_cnt=0, period=0, period counter=0, period_vld=0, irq=0, ovf=0.
REQ-029 Reset mid-measurement discards partial period; first rise after release only arms (WAIT_FIRST).

Structure
REQ-030 Package pulse_meter_pkg holds CNT_W default, state enum (IDLE, WAIT_FIRST, RUN) and mode encoding constants.
REQ-031 One sub-module edge_det (in, in_q register, rise/fall outputs) is instantiated; everything else in pulse_meter.
REQ-032 Connects to upstream filter via its out -> in; irq drives the filter interface irq wire.

Verification
REQ-033 mode=01, thresh=3, en=1, three rising pulses on in -> evt_cnt 1,2,3; irq=1 on third count edge; ack -> irq=0, evt_cnt=0.
REQ-034 mode=11, one pulse of 4 cycles -> evt_cnt=2; mode=00 -> evt_cnt stays 0.
REQ-035 Rising edges 10 cycles apart -> first rise no period_vld; second rise period=10, period_vld one cycle.
REQ-036 CNT_W=4, rises 20 cycles apart -> ovf=1, no period_vld, FSM WAIT_FIRST; ack clears ovf.
REQ-037 thresh=2, irq=1, ack coincident with rise -> irq=0, evt_cnt=1.
REQ-038 rst asserted mid-RUN with evt_cnt=5 -> all outputs 0 immediately (async); next rise gives no period_vld.
